// File: rtl/cross_marker_gen.sv
// Cross-shaped overlay select generator for the LCD pixel path.
// Tracks pixel x/y from the timing signals and delays RGB/timing by one cycle to stay aligned with sel.
module cross_marker_gen #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int ARM_LEN  = 8,
  parameter int HALF_W   = 1,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync_in,
  input  logic          hsync_in,
  input  logic          de_in,
  input  logic [4:0]    r_in,
  input  logic [5:0]    g_in,
  input  logic [4:0]    b_in,
  input  logic          target_valid,
  input  logic [XW-1:0] target_x,
  input  logic [YW-1:0] target_y,
  output logic          vsync_out,
  output logic          hsync_out,
  output logic          de_out,
  output logic [4:0]    r_out,
  output logic [5:0]    g_out,
  output logic [4:0]    b_out,
  output logic          sel,
  output logic          marker_on
);

  localparam int DW = ((XW > YW) ? XW : YW) + 1;

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [XW-1:0] shadow_x;
  logic [YW-1:0] shadow_y;
  logic          shadow_vld;
  logic [XW-1:0] active_x;
  logic [YW-1:0] active_y;
  logic          de_fall;
  logic          vsync_rise;
  logic [DW-1:0] x_ext;
  logic [DW-1:0] y_ext;
  logic [DW-1:0] tx_ext;
  logic [DW-1:0] ty_ext;
  logic [DW-1:0] dx;
  logic [DW-1:0] dy;
  logic          hit;

  // The delayed timing outputs double as the previous-cycle copies for edge detection.
  assign de_fall    = de_out & ~de_in;
  assign vsync_rise = vsync_in & ~vsync_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_out <= 1'b0;
      hsync_out <= 1'b0;
      de_out    <= 1'b0;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
    end else begin
      vsync_out <= vsync_in;
      hsync_out <= hsync_in;
      de_out    <= de_in;
      r_out     <= r_in;
      g_out     <= g_in;
      b_out     <= b_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
    end else if (de_fall) begin
      x_cnt <= '0;
    end else if (de_in && (x_cnt != XW'(H_ACTIVE - 1))) begin
      x_cnt <= x_cnt + 1'b1;
    end
  end

  // Frame start takes priority over the end-of-line increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_cnt <= '0;
    end else if (vsync_rise) begin
      y_cnt <= '0;
    end else if (de_fall && (y_cnt != YW'(V_ACTIVE - 1))) begin
      y_cnt <= y_cnt + 1'b1;
    end
  end

  // Shadow/active pair: the active target only moves at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_x   <= '0;
      shadow_y   <= '0;
      shadow_vld <= 1'b0;
      active_x   <= '0;
      active_y   <= '0;
      marker_on  <= 1'b0;
    end else begin
      if (vsync_rise && shadow_vld) begin
        active_x   <= shadow_x;
        active_y   <= shadow_y;
        marker_on  <= 1'b1;
        shadow_vld <= 1'b0;
      end
      if (target_valid) begin
        shadow_x   <= target_x;
        shadow_y   <= target_y;
        shadow_vld <= 1'b1;
      end
    end
  end

  // Unsigned distances in a widened domain so clipping never wraps.
  always_comb begin
    x_ext  = DW'(x_cnt);
    y_ext  = DW'(y_cnt);
    tx_ext = DW'(active_x);
    ty_ext = DW'(active_y);
    dx     = (x_ext >= tx_ext) ? (x_ext - tx_ext) : (tx_ext - x_ext);
    dy     = (y_ext >= ty_ext) ? (y_ext - ty_ext) : (ty_ext - y_ext);
    hit    = ((dx <= DW'(ARM_LEN)) && (dy <= DW'(HALF_W))) ||
             ((dy <= DW'(ARM_LEN)) && (dx <= DW'(HALF_W)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= 1'b0;
    end else begin
      sel <= de_in & marker_on & hit;
    end
  end

endmodule

// File: tb/tb_cross_marker_gen.sv
// Randomized bench for cross_marker_gen against a coordinate-level reference model.
// The model knows each pixel's position from the frame loops that generate it.
module tb_cross_marker_gen;

  localparam int H   = 480;
  localparam int V   = 272;
  localparam int ARM = 8;
  localparam int HW  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync_in, hsync_in, de_in;
  logic [4:0] r_in, b_in;
  logic [5:0] g_in;
  logic       target_valid;
  logic [9:0] target_x, target_y;
  logic       vsync_out, hsync_out, de_out;
  logic [4:0] r_out, b_out;
  logic [5:0] g_out;
  logic       sel, marker_on;

  int compared   = 0;
  int mismatched = 0;
  int hitCount   = 0;

  int mShX, mShY, mActX, mActY;
  bit mShVld, mOn, prevVs;

  cross_marker_gen dut (
    .clk(clk), .rst(rst),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .de_in(de_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .target_valid(target_valid), .target_x(target_x), .target_y(target_y),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .de_out(de_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .sel(sel), .marker_on(marker_on)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit crossHit(input int x, input int y, input int tx, input int ty);
    int dx, dy;
    dx = iabs(x - tx);
    dy = iabs(y - ty);
    return ((dx <= ARM) && (dy <= HW)) || ((dy <= ARM) && (dx <= HW));
  endfunction

  // Number of on-screen pixels inside the cross for a given centre.
  function automatic int countCross(input int tx, input int ty);
    int n;
    n = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (crossHit(x, y, tx, ty)) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One pixel clock: drive inputs, step the model, then compare the registered outputs.
  task automatic applyStimulus(input bit rstV, input bit vs, input bit de, input int px, input int py,
                               input bit tv, input int tx, input int ty);
    logic [15:0] rgb;
    bit          hs, eSel, eOn, vsRise;
    rgb          = 16'($urandom);
    hs           = 1'($urandom);
    rst          = rstV;
    vsync_in     = vs;
    hsync_in     = hs;
    de_in        = de;
    {r_in, g_in, b_in} = rgb;
    target_valid = tv;
    target_x     = tx[9:0];
    target_y     = ty[9:0];
    if (rstV) begin
      eSel   = 1'b0;
      mOn    = 1'b0;
      mShVld = 1'b0;
      mShX   = 0;
      mShY   = 0;
      mActX  = 0;
      mActY  = 0;
      prevVs = 1'b0;
    end else begin
      eSel   = de && mOn && crossHit(px, py, mActX, mActY);
      vsRise = vs && !prevVs;
      if (vsRise && mShVld) begin
        mActX  = mShX;
        mActY  = mShY;
        mOn    = 1'b1;
        mShVld = 1'b0;
      end
      if (tv) begin
        mShX   = tx;
        mShY   = ty;
        mShVld = 1'b1;
      end
      prevVs = vs;
    end
    eOn = mOn;
    @(posedge clk);
    #1;
    checkOutput("de_out",    de_out,    rstV ? 1'b0 : de);
    checkOutput("vsync_out", vsync_out, rstV ? 1'b0 : vs);
    checkOutput("hsync_out", hsync_out, rstV ? 1'b0 : hs);
    checkOutput("rgb_out",   {r_out, g_out, b_out}, rstV ? 16'h0 : rgb);
    checkOutput("sel",       sel,       eSel);
    checkOutput("marker_on", marker_on, eOn);
    if (sel === 1'b1) hitCount++;
  endtask

  // Lines near the window centres are long enough to cover the cross; the rest are short.
  task automatic runFrame(input int lines, input int wideLen, input int c0, input int c1,
                          input bit followActive, input int strobeLine, input int sTx, input int sTy,
                          input bit strobeAtVsync, input int resetLine, input bit lastGapZero);
    int  w0, wl, len, gap, py;
    bit  wide;
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, strobeAtVsync, sTx, sTy);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    w0 = c0;
    wl = wideLen;
    if (followActive) begin
      w0 = mOn ? mActY : -100;
      wl = imin(mActX + ARM + 4, H + 2);
    end
    for (int ln = 0; ln < lines; ln++) begin
      wide = (iabs(ln - w0) <= ARM + 1) || (iabs(ln - c1) <= ARM + 1);
      len  = wide ? wl : 4;
      py   = imin(ln, V - 1);
      for (int col = 0; col < len; col++)
        applyStimulus((ln == resetLine) && (col == len / 2), 1'b0, 1'b1, imin(col, H - 1), py, 1'b0, 0, 0);
      gap = (lastGapZero && (ln == lines - 1)) ? 0 : 2;
      for (int g = 0; g < gap; g++)
        applyStimulus(1'b0, 1'b0, 1'b0, 0, py, (ln == strobeLine) && (g == 0), sTx, sTy);
    end
  endtask

  initial begin
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);

    hitCount = 0;
    runFrame(V, 4, -100, -100, 1'b0, V - 1, 100, 50, 1'b0, -1, 1'b0);
    checkOutput("hits_no_target", hitCount, 0);

    hitCount = 0;
    runFrame(V, 240, 50, -100, 1'b0, V - 1, 0, 0, 1'b0, -1, 1'b0);
    checkOutput("hits_100_50", hitCount, countCross(100, 50));

    hitCount = 0;
    runFrame(V, 480, 0, V - 1, 1'b0, V - 1, 100, 50, 1'b0, -1, 1'b0);
    checkOutput("hits_0_0", hitCount, countCross(0, 0));

    hitCount = 0;
    runFrame(V, 240, 50, 100, 1'b0, 20, 200, 100, 1'b0, -1, 1'b0);
    checkOutput("hits_hold_mid_frame", hitCount, countCross(100, 50));

    hitCount = 0;
    runFrame(V, 240, -100, 100, 1'b0, -1, 0, 0, 1'b0, -1, 1'b0);
    checkOutput("hits_200_100", hitCount, countCross(200, 100));

    hitCount = 0;
    runFrame(V, 4, -100, -100, 1'b0, 5, 150, 120, 1'b0, 10, 1'b0);
    checkOutput("hits_reset_frame", hitCount, 0);

    hitCount = 0;
    runFrame(V, 240, 100, 120, 1'b0, V - 1, int'($urandom_range(0, H)), int'($urandom_range(0, V + 20)),
             1'b0, -1, 1'b0);
    checkOutput("hits_after_reset", hitCount, 0);

    for (int it = 0; it < 2; it++)
      runFrame(V + int'($urandom_range(0, 2)), 0, -100, -100, 1'b1,
               (it == 0) ? -1 : int'($urandom_range(0, V - 1)),
               int'($urandom_range(0, H)), int'($urandom_range(0, V + 20)),
               it == 0, -1, it == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
